// File: rtl/dm_arbiter_pkg.sv
// Shared defines and types for the dm_arbiter data-memory arbiter.
// Holds the default address/data widths, the starvation limit and the FSM encoding.
`ifndef DM_ARBITER_DEFS
`define DM_ARBITER_DEFS
`define ISIZE 16
`define DSIZE 16
`define DM_MAX_WAIT 4
`endif

package dm_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Wide enough for the largest permitted starvation limit (15).
  localparam int WAIT_W = 4;

endpackage

// File: rtl/dm_arbiter_starve_cnt.sv
// Saturating wait counter for the low-priority requester.
// Reports when the requester has waited MAX_WAIT consecutive cycles.
module dm_starve_cnt #(
  parameter int MAX_WAIT = 4,
  parameter int W        = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req,
  input  logic gnt,
  output logic sat
);

  localparam logic [W-1:0] MAX_C = W'(MAX_WAIT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (en && req && !gnt) begin
      cnt_d = (cnt_q == MAX_C) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat = (cnt_q == MAX_C);

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of a single-ported data memory: port 0 has priority,
// port 1 is promoted after MAX_WAIT blocked cycles. Memory is reset once after rst_n.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int AW       = `ISIZE,
  parameter int DW       = `DSIZE,
  parameter int MAX_WAIT = `DM_MAX_WAIT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_ready,
  output logic          rsp0_valid,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          mem_rst,
  output logic          mem_wen,
  output logic          mem_ren,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          init_done
);

  state_e        state_q, state_d;
  logic          run;
  logic          starve;
  logic          gnt0, gnt1;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rsp0_valid_q, rsp0_valid_d;
  logic          rsp1_valid_q, rsp1_valid_d;

  always_comb begin
    state_d   = state_q;
    run       = 1'b0;
    mem_rst   = 1'b0;
    init_done = 1'b0;
    case (state_q)
      ST_INIT: state_d = ST_LOAD;
      ST_LOAD: begin
        state_d = ST_RUN;
        mem_rst = 1'b1;
      end
      default: begin
        state_d   = ST_RUN;
        run       = 1'b1;
        init_done = 1'b1;
      end
    endcase
  end

  dm_starve_cnt #(
    .MAX_WAIT (MAX_WAIT),
    .W        (WAIT_W)
  ) u_starve (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run),
    .req   (req1_valid),
    .gnt   (gnt1),
    .sat   (starve)
  );

  // Grant is combinational; address/data registers only remember the last grant.
  always_comb begin
    gnt0    = run && req0_valid && (!req1_valid || !starve);
    gnt1    = run && req1_valid && (!req0_valid || starve);
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mem_wen = 1'b0;
    mem_ren = 1'b0;
    if (gnt1) begin
      addr_d  = req1_addr;
      wdata_d = req1_wdata;
      mem_wen = req1_we;
      mem_ren = !req1_we;
    end else if (gnt0) begin
      addr_d  = req0_addr;
      wdata_d = req0_wdata;
      mem_wen = req0_we;
      mem_ren = !req0_we;
    end
    rsp0_valid_d = gnt0 && !req0_we;
    rsp1_valid_d = gnt1 && !req1_we;
    rdata_d      = mem_ren ? mem_rdata : rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign mem_addr   = addr_d;
  assign mem_wdata  = wdata_d;
  assign rsp_rdata  = rdata_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;

endmodule
